// File: rtl/register_file_mp.sv
// register_file_mp: two-read-port register file with write bypass, per-register reservation bits and a mirrored output register
module register_file_mp #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int OUT_IDX = DEPTH - 1,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re_a,
    input  logic [AW-1:0]    raddr_a,
    input  logic             re_b,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_a,
    output logic [WIDTH-1:0] rdata_b,
    output logic             rvalid_a,
    output logic             rvalid_b,
    output logic             busy_a,
    output logic             busy_b,
    input  logic             rsv_en,
    input  logic [AW-1:0]    rsv_addr,
    output logic [WIDTH-1:0] output_reg
);
    localparam logic [AW:0] DL = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] OI = AW'(OUT_IDX);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] pend, pend_nx;
    logic w_ok, s_ok, a_ok, b_ok;
    logic [WIDTH-1:0] rd_a, rd_b;
    assign w_ok = we && ({1'b0, waddr} < DL);
    assign s_ok = rsv_en && ({1'b0, rsv_addr} < DL);
    assign a_ok = {1'b0, raddr_a} < DL;
    assign b_ok = {1'b0, raddr_b} < DL;
    // the set is applied after the clear so a same-cycle reservation wins
    always_comb begin
        pend_nx = pend;
        if (w_ok) pend_nx[waddr] = 1'b0;
        if (s_ok) pend_nx[rsv_addr] = 1'b1;
    end
    assign rd_a = !a_ok ? '0 : (w_ok && waddr == raddr_a) ? wdata : mem[raddr_a];
    assign rd_b = !b_ok ? '0 : (w_ok && waddr == raddr_b) ? wdata : mem[raddr_b];
    assign output_reg = mem[OI];
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            pend     <= '0;
            rdata_a  <= '0;
            rdata_b  <= '0;
            rvalid_a <= 1'b0;
            rvalid_b <= 1'b0;
            busy_a   <= 1'b0;
            busy_b   <= 1'b0;
        end else begin
            if (w_ok) mem[waddr] <= wdata;
            pend     <= pend_nx;
            rvalid_a <= re_a;
            rvalid_b <= re_b;
            if (re_a) begin
                rdata_a <= rd_a;
                busy_a  <= a_ok && pend_nx[raddr_a];
            end
            if (re_b) begin
                rdata_b <= rd_b;
                busy_b  <= b_ok && pend_nx[raddr_b];
            end
        end
    end
endmodule

// File: tb/tb_register_file_mp.sv
// tb_register_file_mp: directed and random scoreboard bench for register_file_mp
module tb_register_file_mp;
    logic clock, reset;
    logic we, re_a, re_b, rsv_en;
    logic [1:0] waddr, raddr_a, raddr_b, rsv_addr;
    logic [7:0] wdata, rdata_a, rdata_b, output_reg;
    logic rvalid_a, rvalid_b, busy_a, busy_b;
    logic we2, re_a2, re_b2, rsv2;
    logic [2:0] waddr2, raddr_a2, raddr_b2, rsv_addr2;
    logic [15:0] wdata2, rdata_a2, rdata_b2, output_reg2;
    logic rvalid_a2, rvalid_b2, busy_a2, busy_b2;
    int total = 0;
    int bad = 0;
    logic [8:0] q_a[$], q_b[$];
    logic [8:0] last_a, last_b;
    logic [7:0] m_regs [4];
    logic [3:0] m_pend;

    register_file_mp dut (
        .clock(clock), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
        .re_a(re_a), .raddr_a(raddr_a), .re_b(re_b), .raddr_b(raddr_b),
        .rdata_a(rdata_a), .rdata_b(rdata_b), .rvalid_a(rvalid_a), .rvalid_b(rvalid_b),
        .busy_a(busy_a), .busy_b(busy_b), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .output_reg(output_reg)
    );

    register_file_mp #(.WIDTH(16), .DEPTH(5)) dut2 (
        .clock(clock), .reset(reset), .we(we2), .waddr(waddr2), .wdata(wdata2),
        .re_a(re_a2), .raddr_a(raddr_a2), .re_b(re_b2), .raddr_b(raddr_b2),
        .rdata_a(rdata_a2), .rdata_b(rdata_b2), .rvalid_a(rvalid_a2), .rvalid_b(rvalid_b2),
        .busy_a(busy_a2), .busy_b(busy_b2), .rsv_en(rsv2), .rsv_addr(rsv_addr2),
        .output_reg(output_reg2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check();
        logic [8:0] e;
        if (q_a.size() != 0) begin
            e = q_a.pop_front();
            chk("rvalid_a", 16'(rvalid_a), 16'd1);
            last_a = e;
        end else chk("rvalid_a", 16'(rvalid_a), 16'd0);
        chk("rdata_a", 16'(rdata_a), 16'(last_a[7:0]));
        chk("busy_a", 16'(busy_a), 16'(last_a[8]));
        if (q_b.size() != 0) begin
            e = q_b.pop_front();
            chk("rvalid_b", 16'(rvalid_b), 16'd1);
            last_b = e;
        end else chk("rvalid_b", 16'(rvalid_b), 16'd0);
        chk("rdata_b", 16'(rdata_b), 16'(last_b[7:0]));
        chk("busy_b", 16'(busy_b), 16'(last_b[8]));
        chk("output_reg", 16'(output_reg), 16'(m_regs[3]));
    endtask

    task automatic cyc(input logic w, input logic [1:0] wa, input logic [7:0] wd,
                       input logic ra_en, input logic [1:0] ra,
                       input logic rb_en, input logic [1:0] rb,
                       input logic rs, input logic [1:0] rsa);
        logic [3:0] pn;
        we = w; waddr = wa; wdata = wd;
        re_a = ra_en; raddr_a = ra; re_b = rb_en; raddr_b = rb;
        rsv_en = rs; rsv_addr = rsa;
        pn = m_pend;
        if (w) pn[wa] = 1'b0;
        if (rs) pn[rsa] = 1'b1;
        if (ra_en) q_a.push_back({pn[ra], (w && wa == ra) ? wd : m_regs[ra]});
        if (rb_en) q_b.push_back({pn[rb], (w && wa == rb) ? wd : m_regs[rb]});
        if (w) m_regs[wa] = wd;
        m_pend = pn;
        @(posedge clock); #1;
        we = 1'b0; re_a = 1'b0; re_b = 1'b0; rsv_en = 1'b0;
        check();
    endtask

    task automatic rst_cyc();
        reset = 1'b1;
        we = 1'b1; waddr = 2'd3; wdata = 8'hEE;
        re_a = 1'b1; raddr_a = 2'd3; re_b = 1'b1; raddr_b = 2'd1;
        rsv_en = 1'b1; rsv_addr = 2'd2;
        @(posedge clock); #1;
        reset = 1'b0;
        we = 1'b0; re_a = 1'b0; re_b = 1'b0; rsv_en = 1'b0;
        q_a.delete(); q_b.delete();
        for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
        m_pend = 4'h0; last_a = 9'h0; last_b = 9'h0;
        check();
        chk("output_reg2_rst", output_reg2, 16'h0);
        chk("rvalid_a2_rst", 16'(rvalid_a2), 16'd0);
    endtask

    initial begin
        reset = 1'b0;
        we = 1'b0; waddr = '0; wdata = '0; re_a = 1'b0; raddr_a = '0;
        re_b = 1'b0; raddr_b = '0; rsv_en = 1'b0; rsv_addr = '0;
        we2 = 1'b0; waddr2 = '0; wdata2 = '0; re_a2 = 1'b0; raddr_a2 = '0;
        re_b2 = 1'b0; raddr_b2 = '0; rsv2 = 1'b0; rsv_addr2 = '0;
        rst_cyc();
        // write then read
        cyc(1'b1, 2'd2, 8'hA5, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0);
        cyc(1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 1'b0, 2'd0, 1'b0, 2'd0);
        chk("wr_rd_data", 16'(rdata_a), 16'h00A5);
        cyc(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0);
        // bypass on port B
        cyc(1'b1, 2'd1, 8'h11, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0);
        cyc(1'b1, 2'd1, 8'h3C, 1'b0, 2'd0, 1'b1, 2'd1, 1'b0, 2'd0);
        chk("bypass_b", 16'(rdata_b), 16'h003C);
        chk("bypass_out", 16'(output_reg), 16'h0000);
        // output mirror
        cyc(1'b1, 2'd3, 8'hF0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0);
        chk("mirror", 16'(output_reg), 16'h00F0);
        // reservations
        cyc(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 2'd3);
        cyc(1'b0, 2'd0, 8'h00, 1'b1, 2'd3, 1'b0, 2'd0, 1'b0, 2'd0);
        chk("rsv_busy", 16'(busy_a), 16'd1);
        cyc(1'b1, 2'd3, 8'h7E, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0);
        cyc(1'b0, 2'd0, 8'h00, 1'b1, 2'd3, 1'b0, 2'd0, 1'b0, 2'd0);
        chk("rsv_clr_busy", 16'(busy_a), 16'd0);
        chk("rsv_clr_data", 16'(rdata_a), 16'h007E);
        cyc(1'b1, 2'd3, 8'h99, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 2'd3);
        cyc(1'b0, 2'd0, 8'h00, 1'b1, 2'd3, 1'b1, 2'd3, 1'b0, 2'd0);
        chk("set_wins", 16'(busy_b), 16'd1);
        cyc(1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 1'b0, 2'd0, 1'b1, 2'd2);
        cyc(1'b1, 2'd0, 8'h42, 1'b1, 2'd0, 1'b1, 2'd0, 1'b0, 2'd0);
        cyc(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0);
        // reset mid-operation
        cyc(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 2'd0);
        cyc(1'b1, 2'd1, 8'h55, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0);
        cyc(1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 1'b0, 2'd0, 1'b0, 2'd0);
        re_a = 1'b1;
        rst_cyc();
        cyc(1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 1'b1, 2'd1, 1'b0, 2'd0);
        chk("post_rst_busy", 16'(busy_a), 16'd0);
        chk("post_rst_data", 16'(rdata_b), 16'h0000);
        for (int i = 0; i < 60; i++)
            cyc(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
                1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
        // WIDTH=16, DEPTH=5 instance
        we2 = 1'b1; waddr2 = 3'd4; wdata2 = 16'hBEEF;
        cyc(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0);
        we2 = 1'b0;
        chk("p_mirror", output_reg2, 16'hBEEF);
        re_a2 = 1'b1; raddr_a2 = 3'd4;
        cyc(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0);
        re_a2 = 1'b0;
        chk("p_rvalid", 16'(rvalid_a2), 16'd1);
        chk("p_rdata", rdata_a2, 16'hBEEF);
        chk("p_busy", 16'(busy_a2), 16'd0);
        we2 = 1'b1; waddr2 = 3'd6; wdata2 = 16'h1234; rsv2 = 1'b1; rsv_addr2 = 3'd5;
        cyc(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0);
        we2 = 1'b0; rsv2 = 1'b0;
        chk("p_rvalid_hold", 16'(rvalid_a2), 16'd0);
        chk("p_rdata_hold", rdata_a2, 16'hBEEF);
        re_a2 = 1'b1; raddr_a2 = 3'd6; re_b2 = 1'b1; raddr_b2 = 3'd5;
        cyc(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0);
        re_a2 = 1'b0; re_b2 = 1'b0;
        chk("p_oor_rvalid", 16'(rvalid_a2), 16'd1);
        chk("p_oor_rdata", rdata_a2, 16'h0000);
        chk("p_oor_busy", 16'(busy_a2), 16'd0);
        chk("p_oor_rvalid_b", 16'(rvalid_b2), 16'd1);
        chk("p_oor_rdata_b", rdata_b2, 16'h0000);
        chk("p_oor_busy_b", 16'(busy_b2), 16'd0);
        re_b2 = 1'b1; raddr_b2 = 3'd4;
        cyc(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0);
        re_b2 = 1'b0;
        chk("p_r4_kept", rdata_b2, 16'hBEEF);
        chk("p_mirror_kept", output_reg2, 16'hBEEF);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
